operand_b_stage: RTL and testbench
==================================

OPERAND_B_STAGE -- requirements
Module: operand_b_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flush  input  1  synchronous pipeline kill, active high.
REQ-005 in_valid  input  1  upstream entry present.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_sel  input  3  operand-B source code, per REQ-015.
REQ-008 in_instr  input  32  raw instruction word carrying immediate fields.
REQ-009 in_rs2  input  XLEN  register-file read port 2 value.
REQ-010 fwd_data  input  XLEN  forwarded result from a later stage (used only when OPB_FWD_EN is defined).
REQ-011 out_valid  output  1  out_opb holds a valid entry.
REQ-012 out_ready  input  1  downstream accepts the entry this cycle.
REQ-013 out_opb  output  XLEN  selected and extended operand B.
REQ-014 out_illegal  output  1  entry carries an illegal selector/shamt, per REQ-018.

Function
REQ-015 in_sel decode SHALL be: 0 in_rs2; 1 I-imm; 2 S-imm; 3 shamt; 4 U-imm; 5 B-imm; 6 J-imm; 7 fwd_data.
REQ-016 Immediates SHALL be built as follows, each sign-extended from instr[31] to XLEN:
 - I-imm = instr[31:20]
 - S-imm = {instr[31:25],instr[11:7]}
 - B-imm = {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
 - J-imm = {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
 - U-imm = {instr[31:12],12'b0}
REQ-017 Shamt SHALL be zero-extended: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-018 out_illegal SHALL be 1 when:
 - in_sel=3, XLEN=32 and instr[25]=1, or
 - in_sel=7 and OPB_FWD_EN is undefined.
 An illegal entry's out_opb SHALL be 0.
REQ-019 The stage SHALL be a 2-entry in-order FIFO; an entry is accepted on a rising edge with in_valid && in_ready.
REQ-020 The operand SHALL be computed at acceptance and stored; latency from acceptance to out_valid SHALL be exactly 1 cycle when the FIFO was empty.
REQ-021 in_ready SHALL be driven from registered occupancy only: 1 when occupancy <2, else 0 (no combinational path from out_ready).
REQ-022 An entry retires on a rising edge with out_valid && out_ready. Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-023 While out_valid && !out_ready, out_opb and out_illegal SHALL hold stable.
REQ-024 flush=1 at a rising edge SHALL empty the FIFO and discard any same-cycle push. Next cycle: out_valid=0, in_ready=1. flush overrides push and pop.
REQ-025 With no pop, occupancy SHALL never exceed 2 and SHALL never underflow.

Reset
REQ-026 While rst_n=0 the stage SHALL hold these values, asynchronously:
 - occupancy 0
 - out_valid 0
 - out_opb 0
 - out_illegal 0
 - in_ready 0
REQ-027 The first rising edge after rst_n deasserts SHALL set in_ready=1. Reset asserted mid-transfer SHALL discard all stored entries.

Configuration
REQ-028 Macro OPB_FWD_EN defined: in_sel=7 SHALL select fwd_data, sampled at acceptance.
REQ-029 Macro OPB_FWD_EN undefined: fwd_data is ignored and in_sel=7 SHALL be treated as illegal per REQ-018.

Verification
REQ-030 XLEN=32, in_sel=1, instr=0xFFF00093 -> one cycle later out_valid=1, out_opb=0xFFFFFFFF, out_illegal=0.
REQ-031 XLEN=64, in_sel=5, instr=0xFE000EE3 -> out_opb=0xFFFFFFFFFFFFFFFC. in_sel=3, instr=0x03F0D093 -> out_opb=0x3F.
REQ-032 out_ready=0, three back-to-back pushes -> in_ready=0 after the second push, third push not accepted, out_opb stable. Raise out_ready -> two entries retire in order.
REQ-033 Two entries stored, then flush=1 concurrent with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing later retires.
REQ-034 XLEN=32, in_sel=7, fwd_data=0x12345678 -> with OPB_FWD_EN: out_opb=0x12345678, out_illegal=0. Without OPB_FWD_EN: out_opb=0, out_illegal=1.
REQ-035 rst_n asserted low with one entry stored -> out_valid=0 and out_opb=0 immediately, before any clock edge.

Source files
------------

// File: rtl/operand_b_stage.sv
// operand_b_stage: selects and extends operand B and buffers it in a 2-entry in-order FIFO.
// Define OPB_FWD_EN to let in_sel=7 select fwd_data; otherwise in_sel=7 is flagged illegal.
module operand_b_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_sel,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_opb,
  output logic            out_illegal
);
  logic [XLEN-1:0] mem_opb [2];
  logic [1:0]      mem_ill;
  logic            wr_ptr, rd_ptr, started, push, pop, ill, unused;
  logic [1:0]      cnt;
  logic [XLEN-1:0] opb, shamt, sel7;
  assign in_ready    = started && cnt != 2'd2;
  assign out_valid   = cnt != 2'd0;
  assign push        = in_valid && in_ready && !flush;
  assign pop         = out_valid && out_ready && !flush;
  assign out_opb     = out_valid ? mem_opb[rd_ptr] : '0;
  assign out_illegal = out_valid && mem_ill[rd_ptr];
  assign shamt       = XLEN == 64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
`ifdef OPB_FWD_EN
  assign ill    = in_sel == 3'd3 && XLEN == 32 && in_instr[25];
  assign sel7   = fwd_data;
  assign unused = ^in_instr[6:0];
`else
  assign ill    = (in_sel == 3'd3 && XLEN == 32 && in_instr[25]) || in_sel == 3'd7;
  assign sel7   = '0;
  assign unused = ^{in_instr[6:0], fwd_data};
`endif
  always_comb
    opb = ill            ? '0 :
          in_sel == 3'd0 ? in_rs2 :
          in_sel == 3'd1 ? XLEN'($signed(in_instr[31:20])) :
          in_sel == 3'd2 ? XLEN'($signed({in_instr[31:25], in_instr[11:7]})) :
          in_sel == 3'd3 ? shamt :
          in_sel == 3'd4 ? XLEN'($signed({in_instr[31:12], 12'b0})) :
          in_sel == 3'd5 ? XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0})) :
          in_sel == 3'd6 ? XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0})) :
                           sel7;
  // started holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_opb <= '{default: '0};
      mem_ill <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      cnt     <= 2'd0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        cnt    <= 2'd0;
      end else begin
        if (push) begin
          mem_opb[wr_ptr] <= opb;
          mem_ill[wr_ptr] <= ill;
          wr_ptr          <= !wr_ptr;
        end
        if (pop) rd_ptr <= !rd_ptr;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
    end
endmodule

// File: tb/tb_operand_b_stage.sv
// tb_operand_b_stage: randomized and directed checks of 32- and 64-bit operand_b_stage against a queue model.
module tb_operand_b_stage;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [2:0] in_sel = 0;
  logic [31:0] in_instr = 0;
  logic [63:0] rs2 = 0, fwd = 0;
  logic ir32, ov32, il32, ir64, ov64, il64;
  logic [31:0] opb32;
  logic [63:0] opb64;
  int checks = 0, failures = 0;
  logic [64:0] q32[$], q64[$];
  bit started = 0;

  operand_b_stage #(.XLEN(32)) d32 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(ir32), .in_sel(in_sel), .in_instr(in_instr), .in_rs2(rs2[31:0]), .fwd_data(fwd[31:0]),
    .out_valid(ov32), .out_ready(out_ready), .out_opb(opb32), .out_illegal(il32));
  operand_b_stage #(.XLEN(64)) d64 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(ir64), .in_sel(in_sel), .in_instr(in_instr), .in_rs2(rs2), .fwd_data(fwd),
    .out_valid(ov64), .out_ready(out_ready), .out_opb(opb64), .out_illegal(il64));

  always #5 clk = ~clk;

  function automatic logic [64:0] ref_op(bit x64, logic [2:0] sel, logic [31:0] ins, logic [63:0] r, logic [63:0] f);
    longint v = 0;
    bit il = 0;
    case (sel)
      3'd0: v = r;
      3'd1: v = $signed(ins[31:20]);
      3'd2: v = $signed({ins[31:25], ins[11:7]});
      3'd3: begin v = x64 ? 64'(ins[25:20]) : 64'(ins[24:20]); il = !x64 && ins[25]; end
      3'd4: v = $signed({ins[31:12], 12'b0});
      3'd5: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3'd6: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      default: begin
`ifdef OPB_FWD_EN
        v = f;
`else
        il = 1;
`endif
      end
    endcase
    if (il) v = 0;
    if (!x64) v = v & 64'hFFFF_FFFF;
    return {il, 64'(v)};
  endfunction

  function automatic bit m_ready(); return started && q32.size() < 2; endfunction
  function automatic bit m_valid(); return q32.size() > 0; endfunction
  function automatic logic [31:0] m_opb32(); return m_valid() ? q32[0][31:0] : 32'h0; endfunction
  function automatic bit m_il32(); return m_valid() ? q32[0][64] : 1'b0; endfunction
  function automatic logic [63:0] m_opb64(); return m_valid() ? q64[0][63:0] : 64'h0; endfunction
  function automatic bit m_il64(); return m_valid() ? q64[0][64] : 1'b0; endfunction

  // advance one clock; inputs are sampled by the model exactly as at the edge
  task automatic step();
    bit push, pop;
    logic [64:0] e32, e64;
    push = in_valid && m_ready() && !flush;
    pop = m_valid() && out_ready && !flush;
    e32 = ref_op(0, in_sel, in_instr, {32'h0, rs2[31:0]}, {32'h0, fwd[31:0]});
    e64 = ref_op(1, in_sel, in_instr, rs2, fwd);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (flush) begin q32.delete(); q64.delete(); end
      else begin
        if (pop) begin void'(q32.pop_front()); void'(q64.pop_front()); end
        if (push) begin q32.push_back(e32); q64.push_back(e64); end
      end
      started = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    checks++; if (ov32 !== 0 || ov64 !== 0) begin failures++; $display("FAIL reset_valid got %b/%b exp 0", ov32, ov64); end
    checks++; if (ir32 !== 0 || ir64 !== 0) begin failures++; $display("FAIL reset_ready got %b/%b exp 0", ir32, ir64); end
    checks++; if (opb32 !== 0 || opb64 !== 0 || il32 !== 0 || il64 !== 0)
      begin failures++; $display("FAIL reset_opb got %h/%h il %b/%b exp 0", opb32, opb64, il32, il64); end
    @(negedge clk);
    rst_n = 1;
    checks++; if (ir32 !== 0) begin failures++; $display("FAIL ready_before_edge got %b exp 0", ir32); end
    step();
    checks++; if (ir32 !== 1 || ir64 !== 1) begin failures++; $display("FAIL ready_after_reset got %b/%b exp 1", ir32, ir64); end
  endtask

  task automatic test_i_imm();
    in_valid = 1; in_sel = 1; in_instr = 32'hFFF0_0093; out_ready = 0;
    step();
    in_valid = 0;
    checks++; if (ov32 !== 1 || opb32 !== 32'hFFFF_FFFF || il32 !== 0)
      begin failures++; $display("FAIL i_imm got v=%b opb=%h il=%b exp v=1 opb=ffffffff il=0", ov32, opb32, il32); end
    checks++; if (opb64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL i_imm64 got %h exp %h", opb64, 64'hFFFF_FFFF_FFFF_FFFF); end
    out_ready = 1;
    step();
    checks++; if (ov32 !== 0) begin failures++; $display("FAIL i_imm_drain got %b exp 0", ov32); end
  endtask

  task automatic test_b_imm_shamt();
    out_ready = 0; in_valid = 1; in_sel = 5; in_instr = 32'hFE00_0EE3;
    step();
    in_valid = 0;
    checks++; if (opb64 !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL b_imm64 got %h exp fffffffffffffffc", opb64); end
    checks++; if (opb32 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL b_imm32 got %h exp fffffffc", opb32); end
    out_ready = 1; in_valid = 1; in_sel = 3; in_instr = 32'h03F0_D093;
    step();
    in_valid = 0; out_ready = 0;
    checks++; if (opb64 !== 64'h3F || il64 !== 0) begin failures++; $display("FAIL shamt64 got %h il=%b exp 3f il=0", opb64, il64); end
    checks++; if (opb32 !== 0 || il32 !== 1) begin failures++; $display("FAIL shamt32_illegal got %h il=%b exp 0 il=1", opb32, il32); end
    out_ready = 1;
    step();
  endtask

  task automatic test_fwd();
    out_ready = 0; in_valid = 1; in_sel = 7; fwd = 64'h0000_0000_1234_5678;
    step();
    in_valid = 0; fwd = 0;
`ifdef OPB_FWD_EN
    checks++; if (opb32 !== 32'h1234_5678 || il32 !== 0) begin failures++; $display("FAIL fwd got %h il=%b exp 12345678 il=0", opb32, il32); end
`else
    checks++; if (opb32 !== 0 || il32 !== 1) begin failures++; $display("FAIL fwd got %h il=%b exp 0 il=1", opb32, il32); end
`endif
    out_ready = 1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] first;
    logic [31:0] ins[3];
    out_ready = 0; in_valid = 1; in_sel = 1;
    for (int i = 0; i < 3; i++) begin
      ins[i] = $urandom; in_instr = ins[i];
      step();
      if (i == 0) first = opb32;
      checks++; if (ir32 !== (i == 0)) begin failures++; $display("FAIL b2b_ready push%0d got %b exp %b", i, ir32, i == 0); end
    end
    in_valid = 0;
    checks++; if (opb32 !== first || opb32 !== 32'($signed(ins[0][31:20])))
      begin failures++; $display("FAIL b2b_stable got %h exp %h", opb32, 32'($signed(ins[0][31:20]))); end
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (ov32 !== 1 || opb32 !== 32'($signed(ins[i][31:20])))
        begin failures++; $display("FAIL b2b_order %0d got v=%b %h exp %h", i, ov32, opb32, 32'($signed(ins[i][31:20]))); end
      step();
    end
    checks++; if (ov32 !== 0 || q32.size() != 0) begin failures++; $display("FAIL b2b_third_dropped got v=%b exp 0", ov32); end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_sel = 0; rs2 = 64'hDEAD;
    step(); step();
    flush = 1;
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    checks++; if (ov32 !== 0 || ir32 !== 1 || ov64 !== 0 || ir64 !== 1)
      begin failures++; $display("FAIL flush got v=%b r=%b exp v=0 r=1", ov32, ir32); end
    step(); step();
    checks++; if (ov32 !== 0) begin failures++; $display("FAIL flush_nothing_retires got %b exp 0", ov32); end
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1; in_sel = 0; rs2 = 64'h5555_AAAA_1234_0001;
    step();
    in_valid = 0;
    checks++; if (ov32 !== 1 || opb32 !== 32'h1234_0001) begin failures++; $display("FAIL pre_reset got v=%b %h exp 1 12340001", ov32, opb32); end
    #2 rst_n = 0;
    #1;
    checks++; if (ov32 !== 0 || opb32 !== 0 || ov64 !== 0 || opb64 !== 0)
      begin failures++; $display("FAIL async_reset got v=%b %h exp 0 0", ov32, opb32); end
    q32.delete(); q64.delete(); started = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    checks++; if (ir32 !== 1 || ov32 !== 0) begin failures++; $display("FAIL post_reset got r=%b v=%b exp 1 0", ir32, ov32); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom % 4) != 0; out_ready = ($urandom % 3) != 0; flush = ($urandom % 25) == 0;
      in_sel = 3'($urandom); in_instr = $urandom; rs2 = {$urandom, $urandom}; fwd = {$urandom, $urandom};
      step();
      checks++;
      if (ov32 !== m_valid() || ir32 !== m_ready() || opb32 !== m_opb32() || il32 !== m_il32() ||
          ov64 !== m_valid() || ir64 !== m_ready() || opb64 !== m_opb64() || il64 !== m_il64()) begin
        failures++;
        if (bad++ < 10) $display("FAIL random cyc%0d got v=%b r=%b %h il=%b / %h il=%b exp v=%b r=%b %h il=%b / %h il=%b",
          n, ov32, ir32, opb32, il32, opb64, il64, m_valid(), m_ready(), m_opb32(), m_il32(), m_opb64(), m_il64());
      end
    end
    flush = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_i_imm();
    test_b_imm_shamt();
    test_fwd();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
